// File: rtl/regfile_pkg.sv
// Shared constants and port-slicing helpers for the multi-port register file.
package regfile_pkg;

  localparam int DW_DEF   = 32;
  localparam int NREG_DEF = 32;
  localparam int NR_DEF   = 4;
  localparam int NW_DEF   = 2;
  localparam int ZERO_REG = 0;

  // Low bit of field idx inside a flat vector of w-bit fields.
  function automatic int unsigned port_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets, committed writeback clears, flush wipes.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG_DEF),
  parameter int NR   = NR_DEF,
  parameter int NW   = NW_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic [NW-1:0]    iss_en,
  input  logic [NW*AW-1:0] iss_addr,
  input  logic [NW-1:0]    commit,
  input  logic [NW*AW-1:0] wa,
  input  logic [NR*AW-1:0] ra,
  input  logic [NR-1:0]    byp_hit,
  output logic [NR-1:0]    rdy
);

  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] busy_nxt_s;

  // Later assignments override earlier ones: clear < set < flush; r0 is never busy.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 0; i < NW; i++) begin
      busy_nxt_s[wa[port_lo(i, AW) +: AW]] =
        commit[i] ? 1'b0 : busy_nxt_s[wa[port_lo(i, AW) +: AW]];
    end
    for (int i = 0; i < NW; i++) begin
      busy_nxt_s[iss_addr[port_lo(i, AW) +: AW]] =
        iss_en[i] ? 1'b1 : busy_nxt_s[iss_addr[port_lo(i, AW) +: AW]];
    end
    busy_nxt_s = flush ? {NREG{1'b0}} : busy_nxt_s;
    busy_nxt_s[ZERO_REG] = 1'b0;
  end

  // Busy vector state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Operand-ready lookup per read port.
  always_comb begin
    rdy = {NR{1'b0}};
    for (int j = 0; j < NR; j++) begin
      rdy[j] = ~busy_r[ra[port_lo(j, AW) +: AW]] | byp_hit[j];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// NR-read / NW-write register file with busy scoreboard.
// Optional same-cycle write-to-read bypass under `define REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DW   = DW_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NR   = NR_DEF,
  parameter  int NW   = NW_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             stall_w,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] wa,
  input  logic [NW*DW-1:0] wd,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*DW-1:0] rd,
  output logic [NR-1:0]    rdy,
  input  logic [NW-1:0]    iss_en,
  input  logic [NW*AW-1:0] iss_addr,
  input  logic             flush
);

  localparam logic [AW-1:0] R0 = AW'(ZERO_REG);

  logic [DW-1:0] rf_r [NREG];
  logic [NW-1:0] commit_s;
  logic [NR-1:0] byp_hit_s;

  // A write commits only when enabled, not stalled and not aimed at r0.
  always_comb begin
    commit_s = {NW{1'b0}};
    for (int i = 0; i < NW; i++) begin
      commit_s[i] = we[i] & ~stall_w & (wa[port_lo(i, AW) +: AW] != R0);
    end
  end

  // Storage; ascending port loop lets the highest-index writer win a conflict.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) begin
        rf_r[r] <= {DW{1'b0}};
      end
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (commit_s[i]) begin
          rf_r[wa[port_lo(i, AW) +: AW]] <= wd[port_lo(i, DW) +: DW];
        end
      end
    end
  end

  // Read muxes, with optional forwarding from committing write ports.
  always_comb begin
    rd        = {NR*DW{1'b0}};
    byp_hit_s = {NR{1'b0}};
    for (int j = 0; j < NR; j++) begin
      rd[port_lo(j, DW) +: DW] = (ra[port_lo(j, AW) +: AW] == R0) ? {DW{1'b0}}
                                 : rf_r[ra[port_lo(j, AW) +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int i = 0; i < NW; i++) begin
        byp_hit_s[j] = byp_hit_s[j] |
                       (commit_s[i] & (wa[port_lo(i, AW) +: AW] == ra[port_lo(j, AW) +: AW]));
        rd[port_lo(j, DW) +: DW] =
          (commit_s[i] & (wa[port_lo(i, AW) +: AW] == ra[port_lo(j, AW) +: AW]))
            ? wd[port_lo(i, DW) +: DW] : rd[port_lo(j, DW) +: DW];
      end
`else
      byp_hit_s[j] = 1'b0;
`endif
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW),
    .NR   (NR),
    .NW   (NW)
  ) u_sb (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .commit   (commit_s),
    .wa       (wa),
    .ra       (ra),
    .byp_hit  (byp_hit_s),
    .rdy      (rdy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: stimulus queues expected reads, a negedge monitor checks them.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk;
  logic             resetn;
  logic             stall_w;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] wa;
  logic [NW*DW-1:0] wd;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd;
  logic [NR-1:0]    rdy;
  logic [NW-1:0]    iss_en;
  logic [NW*AW-1:0] iss_addr;
  logic             flush;

  typedef struct packed {
    logic [1:0]    port;
    logic [DW-1:0] rd;
    logic          rdy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp;
  int    n_err;
  exp_t  mon_e;
  string mon_nm;

  regfile_mp dut (
    .clk      (clk),
    .resetn   (resetn),
    .stall_w  (stall_w),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .ra       (ra),
    .rd       (rd),
    .rdy      (rdy),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    we = '0; wa = '0; wd = '0; ra = '0;
    iss_en = '0; iss_addr = '0; flush = 1'b0; stall_w = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[p] = 1'b1;
    wa[p*AW +: AW] = a;
    wd[p*DW +: DW] = d;
  endtask

  task automatic iss(input int p, input logic [AW-1:0] a);
    iss_en[p] = 1'b1;
    iss_addr[p*AW +: AW] = a;
  endtask

  task automatic chk(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic r, input string nm);
    exp_t e;
    ra[p*AW +: AW] = a;
    e.port = 2'(p);
    e.rd   = d;
    e.rdy  = r;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        mon_e  = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        n_cmp++;
        if (rd[int'(mon_e.port)*DW +: DW] !== mon_e.rd || rdy[mon_e.port] !== mon_e.rdy) begin
          n_err++;
          $display("FAIL %s: got rd=%h rdy=%b, expected rd=%h rdy=%b", mon_nm,
                   rd[int'(mon_e.port)*DW +: DW], rdy[mon_e.port], mon_e.rd, mon_e.rdy);
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_err = 0;
    resetn = 1'b0; stall_w = 1'b0; we = '0; wa = '0; wd = '0; ra = '0;
    iss_en = '0; iss_addr = '0; flush = 1'b0;

    // Reset state, during and after reset
    tick();
    chk(0, 5'd0, 32'h0, 1'b1, "rst_r0"); chk(1, 5'd1, 32'h0, 1'b1, "rst_r1");
    chk(2, 5'd5, 32'h0, 1'b1, "rst_r5"); chk(3, 5'd31, 32'h0, 1'b1, "rst_r31");
    tick();
    resetn = 1'b1;
    chk(0, 5'd0, 32'h0, 1'b1, "rel_r0"); chk(1, 5'd1, 32'h0, 1'b1, "rel_r1");
    chk(2, 5'd5, 32'h0, 1'b1, "rel_r5"); chk(3, 5'd31, 32'h0, 1'b1, "rel_r31");

    // Dual write, then write-write conflict
    tick();
    wr(0, 5'd3, 32'hAAAA0000); wr(1, 5'd7, 32'h5555FFFF);
    tick();
    wr(0, 5'd9, 32'h00000001); wr(1, 5'd9, 32'h00000002);
    chk(0, 5'd3, 32'hAAAA0000, 1'b1, "wr_r3"); chk(1, 5'd7, 32'h5555FFFF, 1'b1, "wr_r7");
    tick();
    chk(0, 5'd9, 32'h00000002, 1'b1, "ww_conflict_r9");

    // Stall suppresses writes, issue still acts; r0 stays zero
    tick();
    stall_w = 1'b1; wr(0, 5'd4, 32'h12345678); iss(0, 5'd11);
    tick();
    wr(1, 5'd0, 32'hFFFFFFFF); iss(1, 5'd0);
    chk(0, 5'd4, 32'h0, 1'b1, "stall_r4"); chk(1, 5'd11, 32'h0, 1'b0, "stall_iss_r11");
    tick();
    chk(0, 5'd0, 32'h0, 1'b1, "r0_zero");
    stall_w = 1'b1; wr(0, 5'd11, 32'h11111111);
    tick();
    chk(0, 5'd11, 32'h0, 1'b0, "stall_noclear_r11");

    // Scoreboard set / set-over-clear / clear
    iss(0, 5'd6);
    tick();
    chk(0, 5'd6, 32'h0, 1'b0, "iss_r6");
    tick();
    wr(0, 5'd6, 32'h00000066); iss(1, 5'd6);
    tick();
    chk(0, 5'd6, 32'h00000066, 1'b0, "set_over_clr_r6");
    tick();
    wr(0, 5'd6, 32'h00000077);
    tick();
    chk(0, 5'd6, 32'h00000077, 1'b1, "clr_r6");
    iss(0, 5'd13);

    // Flush beats a same-cycle issue and clears everything
    tick();
    flush = 1'b1; iss(0, 5'd8);
    chk(0, 5'd13, 32'h0, 1'b0, "busy_r13"); chk(1, 5'd11, 32'h0, 1'b0, "busy_r11");
    tick();
    chk(0, 5'd8, 32'h0, 1'b1, "flush_iss_r8"); chk(1, 5'd13, 32'h0, 1'b1, "flush_r13");
    chk(2, 5'd11, 32'h0, 1'b1, "flush_r11");
    wr(0, 5'd10, 32'h00000A0A); wr(1, 5'd12, 32'h0000BEEF);

    // Same-cycle read of a register being written
    tick();
    iss(0, 5'd10);
    chk(0, 5'd12, 32'h0000BEEF, 1'b1, "wr_r12");
    tick();
    wr(0, 5'd10, 32'hCAFEBABE);
    chk(0, 5'd10, BYP ? 32'hCAFEBABE : 32'h00000A0A, BYP, "bypass_r10");
    tick();
    chk(0, 5'd10, 32'hCAFEBABE, 1'b1, "post_wr_r10");
    iss(0, 5'd15);

    // Async reset between edges during a pending write
    tick();
    wr(0, 5'd12, 32'h12121212); iss(1, 5'd14);
    chk(0, 5'd12, 32'h0, 1'b1, "arst_r12"); chk(1, 5'd15, 32'h0, 1'b1, "arst_r15");
    chk(2, 5'd3, 32'h0, 1'b1, "arst_r3");   chk(3, 5'd14, 32'h0, 1'b1, "arst_r14");
    #2 resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk(0, 5'd12, 32'h0, 1'b1, "post_rst_r12"); chk(1, 5'd10, 32'h0, 1'b1, "post_rst_r10");
    tick();

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
